leaf_uplink_port: RTL and testbench

- Leaf-side endpoint of the leaf↔spine link. It is the opposite end of the spine router's leaf ports (spineNx_in/out).
- TX path: buffers local flits and sends them toward the spine under credit-based flow control. The spine port has no ready signal, so credits are the only protection for its FIFO.
- RX path: captures spine flits into an RX FIFO that the local leaf logic drains with valid/ready.
- One instance per spine uplink of a leaf router.

---
 rtl/leaf_uplink_port.sv | 166 ++++++++++++++++
 tb/tb_leaf_uplink_port.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_uplink_port.sv
// Leaf-side end of a leaf<->spine link: credit-controlled TX toward the spine, valid/ready RX FIFO toward the leaf.
// Optional flit counters (tx_flit_count, rx_flit_count) are built when UPLINK_STATS_EN is defined.
module leaf_uplink_port #(
  parameter logic [3:0] GROUP_ID   = 4'b0001,
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter int         CREDITS    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DWIDTH-1:0]              loc_tx_data,
  input  logic                           loc_tx_valid,
  output logic                           loc_tx_ready,
  output logic [DWIDTH-1:0]              up_tx_data,
  output logic                           up_tx_valid,
  input  logic                           up_credit_ret,
  input  logic [DWIDTH-1:0]              up_rx_data,
  input  logic                           up_rx_valid,
  output logic [DWIDTH-1:0]              loc_rx_data,
  output logic                           loc_rx_valid,
  input  logic                           loc_rx_ready,
  output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
  output logic                           rx_overflow,
  output logic                           rx_misroute
`ifdef UPLINK_STATS_EN
  ,
  output logic [15:0]                    tx_flit_count,
  output logic [15:0]                    rx_flit_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic [1:0] {IDLE, SEND, STALL} tx_state_t;

  tx_state_t state, state_next;

  logic [DWIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0]     tx_wr, tx_rd;
  logic              tx_empty, tx_full, tx_push, tx_send;
  logic [CW-1:0]     credit_next;

  logic [DWIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0]     rx_wr, rx_rd;
  logic              rx_empty, rx_full, rx_push, rx_pop;

  // Extra pointer bit tells full from empty when the index bits match.
  assign tx_empty     = (tx_wr == tx_rd);
  assign tx_full      = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign loc_tx_ready = !tx_full;
  assign tx_push      = loc_tx_valid && !tx_full;

  // Sending is also allowed on the IDLE/STALL exit edge so a lone flit reaches the spine one edge after its push.
  always_comb begin
    state_next = state;
    tx_send    = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_empty) begin
          if (credit_cnt != '0) begin
            tx_send    = 1'b1;
            state_next = SEND;
          end else begin
            state_next = STALL;
          end
        end
      end
      SEND: begin
        if (tx_empty)               state_next = IDLE;
        else if (credit_cnt == '0)  state_next = STALL;
        else                        tx_send    = 1'b1;
      end
      STALL: begin
        if (credit_cnt != '0) begin
          state_next = SEND;
          tx_send    = !tx_empty;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A return with a simultaneous send nets to zero; a lone return saturates at CREDITS.
  always_comb begin
    credit_next = credit_cnt;
    if (tx_send && !up_credit_ret)
      credit_next = credit_cnt - CW'(1);
    else if (!tx_send && up_credit_ret && (credit_cnt != CRED_MAX))
      credit_next = credit_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tx_wr       <= '0;
      tx_rd       <= '0;
      up_tx_valid <= 1'b0;
      up_tx_data  <= '0;
      credit_cnt  <= CRED_MAX;
    end else begin
      state       <= state_next;
      credit_cnt  <= credit_next;
      up_tx_valid <= tx_send;
      if (tx_push)
        tx_wr <= tx_wr + PW'(1);
      if (tx_send) begin
        tx_rd      <= tx_rd + PW'(1);
        up_tx_data <= tx_mem[tx_rd[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wr[AW-1:0]] <= loc_tx_data;
  end

  assign rx_empty     = (rx_wr == rx_rd);
  assign rx_full      = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign loc_rx_valid = !rx_empty;
  assign loc_rx_data  = rx_mem[rx_rd[AW-1:0]];
  assign rx_pop       = loc_rx_valid && loc_rx_ready;
  assign rx_push      = up_rx_valid && (!rx_full || rx_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr       <= '0;
      rx_rd       <= '0;
      rx_overflow <= 1'b0;
      rx_misroute <= 1'b0;
    end else begin
      if (rx_push)
        rx_wr <= rx_wr + PW'(1);
      if (rx_pop)
        rx_rd <= rx_rd + PW'(1);
      if (up_rx_valid && rx_full && !rx_pop)
        rx_overflow <= 1'b1;
      if (up_rx_valid && (up_rx_data[DWIDTH-1:DWIDTH-4] != GROUP_ID))
        rx_misroute <= 1'b1;
    end
  end

  // On push+pop while full the write lands in the slot being vacated by the pop.
  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[rx_wr[AW-1:0]] <= up_rx_data;
  end

`ifdef UPLINK_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_flit_count <= '0;
      rx_flit_count <= '0;
    end else begin
      if (up_tx_valid && (tx_flit_count != 16'hFFFF))
        tx_flit_count <= tx_flit_count + 16'd1;
      if (rx_push && (rx_flit_count != 16'hFFFF))
        rx_flit_count <= rx_flit_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_leaf_uplink_port.sv
// Scoreboard bench for leaf_uplink_port: TX credit flow, RX FIFO, sticky flags and mid-burst reset.
module tb_leaf_uplink_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] loc_tx_data = '0;
  logic        loc_tx_valid = 1'b0;
  logic        loc_tx_ready;
  logic [15:0] up_tx_data;
  logic        up_tx_valid;
  logic        up_credit_ret = 1'b0;
  logic [15:0] up_rx_data = '0;
  logic        up_rx_valid = 1'b0;
  logic [15:0] loc_rx_data;
  logic        loc_rx_valid;
  logic        loc_rx_ready = 1'b0;
  logic [3:0]  credit_cnt;
  logic        rx_overflow;
  logic        rx_misroute;
`ifdef UPLINK_STATS_EN
  logic [15:0] tx_flit_count, rx_flit_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] tx_exp[$];
  logic [15:0] rx_exp[$];

  always #5 clk = ~clk;

  leaf_uplink_port dut (
    .clk           (clk),
    .reset         (reset),
    .loc_tx_data   (loc_tx_data),
    .loc_tx_valid  (loc_tx_valid),
    .loc_tx_ready  (loc_tx_ready),
    .up_tx_data    (up_tx_data),
    .up_tx_valid   (up_tx_valid),
    .up_credit_ret (up_credit_ret),
    .up_rx_data    (up_rx_data),
    .up_rx_valid   (up_rx_valid),
    .loc_rx_data   (loc_rx_data),
    .loc_rx_valid  (loc_rx_valid),
    .loc_rx_ready  (loc_rx_ready),
    .credit_cnt    (credit_cnt),
    .rx_overflow   (rx_overflow),
    .rx_misroute   (rx_misroute)
`ifdef UPLINK_STATS_EN
    ,
    .tx_flit_count (tx_flit_count),
    .rx_flit_count (rx_flit_count)
`endif
  );

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (up_tx_valid !== 1'b0) $display("[TB] FAIL reset_tx_valid: got %b want 0", up_tx_valid); else n_pass++;
    n_checks++; if (up_tx_data !== 16'h0) $display("[TB] FAIL reset_tx_data: got %h want 0000", up_tx_data); else n_pass++;
    n_checks++; if (loc_rx_valid !== 1'b0) $display("[TB] FAIL reset_rx_valid: got %b want 0", loc_rx_valid); else n_pass++;
    n_checks++; if (credit_cnt !== 4'd8) $display("[TB] FAIL reset_credit: got %0d want 8", credit_cnt); else n_pass++;
    n_checks++; if (rx_overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b want 0", rx_overflow); else n_pass++;
    n_checks++; if (rx_misroute !== 1'b0) $display("[TB] FAIL reset_misroute: got %b want 0", rx_misroute); else n_pass++;
    n_checks++; if (loc_tx_ready !== 1'b1) $display("[TB] FAIL reset_tx_ready: got %b want 1", loc_tx_ready); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tx_basic();
    logic exp_v;
    logic [15:0] e;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_v = (k >= 2) && (k <= 4);
      n_checks++; if (up_tx_valid !== exp_v) $display("[TB] FAIL tx_basic_valid[%0d]: got %b want %b", k, up_tx_valid, exp_v); else n_pass++;
      if (up_tx_valid === 1'b1 && tx_exp.size() > 0) begin
        e = tx_exp.pop_front();
        n_checks++; if (up_tx_data !== e) $display("[TB] FAIL tx_basic_data[%0d]: got %h want %h", k, up_tx_data, e); else n_pass++;
      end
      loc_tx_valid = (k < 3);
      if (k < 3) begin
        loc_tx_data = 16'h1234 + 16'(k);
        tx_exp.push_back(loc_tx_data);
      end
    end
    n_checks++; if (credit_cnt !== 4'd5) $display("[TB] FAIL tx_basic_credit: got %0d want 5", credit_cnt); else n_pass++;
    up_credit_ret = 1'b1;
    repeat (3) @(negedge clk);
    up_credit_ret = 1'b0;
    n_checks++; if (credit_cnt !== 4'd8) $display("[TB] FAIL tx_basic_credit_restore: got %0d want 8", credit_cnt); else n_pass++;
  endtask

  task automatic test_credit_stall();
    int pushed, sent, found;
    logic [15:0] e;
    pushed = 0;
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (up_tx_valid === 1'b1) begin
        sent++;
        n_checks++;
        if (tx_exp.size() == 0) $display("[TB] FAIL stall_extra_flit: got %h want none", up_tx_data);
        else begin
          e = tx_exp.pop_front();
          if (up_tx_data !== e) $display("[TB] FAIL stall_data: got %h want %h", up_tx_data, e); else n_pass++;
        end
      end
      loc_tx_valid = 1'b0;
      if (pushed < 10 && loc_tx_ready === 1'b1) begin
        loc_tx_valid = 1'b1;
        loc_tx_data  = 16'hA000 + 16'(pushed);
        tx_exp.push_back(loc_tx_data);
        pushed++;
      end
    end
    n_checks++; if (sent != 8) $display("[TB] FAIL stall_sent_count: got %0d want 8", sent); else n_pass++;
    n_checks++; if (credit_cnt !== 4'd0) $display("[TB] FAIL stall_credit: got %0d want 0", credit_cnt); else n_pass++;
    n_checks++; if (up_tx_valid !== 1'b0) $display("[TB] FAIL stall_valid: got %b want 0", up_tx_valid); else n_pass++;
    for (int p = 0; p < 2; p++) begin
      up_credit_ret = 1'b1;
      found = 0;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        up_credit_ret = 1'b0;
        if (up_tx_valid === 1'b1) begin
          found++;
          if (tx_exp.size() > 0) begin
            e = tx_exp.pop_front();
            n_checks++; if (up_tx_data !== e) $display("[TB] FAIL stall_release_data[%0d]: got %h want %h", p, up_tx_data, e); else n_pass++;
          end
        end
      end
      n_checks++; if (found != 1) $display("[TB] FAIL stall_release_count[%0d]: got %0d want 1", p, found); else n_pass++;
    end
    n_checks++; if (credit_cnt !== 4'd0) $display("[TB] FAIL stall_credit_after: got %0d want 0", credit_cnt); else n_pass++;
    up_credit_ret = 1'b1;
    repeat (8) @(negedge clk);
    up_credit_ret = 1'b0;
    n_checks++; if (credit_cnt !== 4'd8) $display("[TB] FAIL stall_credit_restore: got %0d want 8", credit_cnt); else n_pass++;
  endtask

  task automatic test_credit_same_cycle();
    logic [15:0] e;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (up_tx_valid === 1'b1 && tx_exp.size() > 0) begin
        e = tx_exp.pop_front();
        n_checks++; if (up_tx_data !== e) $display("[TB] FAIL same_cycle_fill_data: got %h want %h", up_tx_data, e); else n_pass++;
      end
      loc_tx_valid = (c < 4);
      if (c < 4) begin
        loc_tx_data = 16'hB000 + 16'(c);
        tx_exp.push_back(loc_tx_data);
      end
    end
    n_checks++; if (credit_cnt !== 4'd4) $display("[TB] FAIL same_cycle_pre_credit: got %0d want 4", credit_cnt); else n_pass++;
    loc_tx_valid = 1'b1;
    loc_tx_data  = 16'hB004;
    tx_exp.push_back(16'hB004);
    @(negedge clk);
    loc_tx_valid  = 1'b0;
    up_credit_ret = 1'b1;
    @(negedge clk);
    up_credit_ret = 1'b0;
    n_checks++; if (up_tx_valid !== 1'b1) $display("[TB] FAIL same_cycle_valid: got %b want 1", up_tx_valid); else n_pass++;
    e = tx_exp.pop_front();
    n_checks++; if (up_tx_data !== e) $display("[TB] FAIL same_cycle_data: got %h want %h", up_tx_data, e); else n_pass++;
    n_checks++; if (credit_cnt !== 4'd4) $display("[TB] FAIL same_cycle_credit: got %0d want 4", credit_cnt); else n_pass++;
    up_credit_ret = 1'b1;
    repeat (4) @(negedge clk);
    up_credit_ret = 1'b0;
    n_checks++; if (credit_cnt !== 4'd8) $display("[TB] FAIL credit_refill: got %0d want 8", credit_cnt); else n_pass++;
    up_credit_ret = 1'b1;
    @(negedge clk);
    up_credit_ret = 1'b0;
    n_checks++; if (credit_cnt !== 4'd8) $display("[TB] FAIL credit_saturate: got %0d want 8", credit_cnt); else n_pass++;
  endtask

  task automatic test_rx_overflow();
    int got;
    logic [15:0] e;
    loc_rx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_checks++; if (loc_rx_valid !== 1'b1) $display("[TB] FAIL rx_latency: got %b want 1", loc_rx_valid); else n_pass++;
      end
      if (i == 8) begin
        n_checks++; if (rx_overflow !== 1'b0) $display("[TB] FAIL rx_overflow_early: got %b want 0", rx_overflow); else n_pass++;
      end
      up_rx_valid = 1'b1;
      up_rx_data  = 16'h1000 + 16'(i);
      if (i < 8) rx_exp.push_back(up_rx_data);
    end
    @(negedge clk);
    up_rx_valid = 1'b0;
    n_checks++; if (rx_overflow !== 1'b1) $display("[TB] FAIL rx_overflow_set: got %b want 1", rx_overflow); else n_pass++;
    n_checks++; if (rx_misroute !== 1'b0) $display("[TB] FAIL rx_misroute_clean: got %b want 0", rx_misroute); else n_pass++;
    loc_rx_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (loc_rx_valid === 1'b1) begin
        got++;
        n_checks++;
        if (rx_exp.size() == 0) $display("[TB] FAIL rx_extra_flit: got %h want none", loc_rx_data);
        else begin
          e = rx_exp.pop_front();
          if (loc_rx_data !== e) $display("[TB] FAIL rx_drain_data: got %h want %h", loc_rx_data, e); else n_pass++;
        end
      end
      @(negedge clk);
    end
    loc_rx_ready = 1'b0;
    n_checks++; if (got != 8) $display("[TB] FAIL rx_drain_count: got %0d want 8", got); else n_pass++;
    n_checks++; if (rx_overflow !== 1'b1) $display("[TB] FAIL rx_overflow_sticky: got %b want 1", rx_overflow); else n_pass++;
    n_checks++; if (loc_rx_valid !== 1'b0) $display("[TB] FAIL rx_empty_after_drain: got %b want 0", loc_rx_valid); else n_pass++;
  endtask

  task automatic test_misroute();
    @(negedge clk);
    up_rx_valid = 1'b1;
    up_rx_data  = 16'h2ABC;
    @(negedge clk);
    up_rx_valid = 1'b0;
    n_checks++; if (rx_misroute !== 1'b1) $display("[TB] FAIL misroute_flag: got %b want 1", rx_misroute); else n_pass++;
    n_checks++; if (loc_rx_valid !== 1'b1) $display("[TB] FAIL misroute_valid: got %b want 1", loc_rx_valid); else n_pass++;
    n_checks++; if (loc_rx_data !== 16'h2ABC) $display("[TB] FAIL misroute_data: got %h want 2abc", loc_rx_data); else n_pass++;
    loc_rx_ready = 1'b1;
    @(negedge clk);
    loc_rx_ready = 1'b0;
    n_checks++; if (loc_rx_valid !== 1'b0) $display("[TB] FAIL misroute_pop: got %b want 0", loc_rx_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int stale;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      loc_tx_valid = (c < 5);
      loc_tx_data  = 16'hC000 + 16'(c);
    end
    n_checks++; if (credit_cnt !== 4'd3) $display("[TB] FAIL burst_pre_credit: got %0d want 3", credit_cnt); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      loc_tx_valid = 1'b1;
      loc_tx_data  = 16'hD000 + 16'(c);
      up_rx_valid  = (c == 0);
      up_rx_data   = 16'h1111;
    end
    @(negedge clk);
    n_checks++; if (up_tx_valid !== 1'b1) $display("[TB] FAIL burst_pre_valid: got %b want 1", up_tx_valid); else n_pass++;
    reset = 1'b0;
    loc_tx_valid = 1'b0;
    up_rx_valid  = 1'b0;
    #1;
    n_checks++; if (up_tx_valid !== 1'b0) $display("[TB] FAIL burst_reset_valid: got %b want 0", up_tx_valid); else n_pass++;
    n_checks++; if (loc_rx_valid !== 1'b0) $display("[TB] FAIL burst_reset_rx_valid: got %b want 0", loc_rx_valid); else n_pass++;
    n_checks++; if (credit_cnt !== 4'd8) $display("[TB] FAIL burst_reset_credit: got %0d want 8", credit_cnt); else n_pass++;
    n_checks++; if (loc_tx_ready !== 1'b1) $display("[TB] FAIL burst_reset_ready: got %b want 1", loc_tx_ready); else n_pass++;
    tx_exp.delete();
    rx_exp.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (up_tx_valid === 1'b1) stale++;
    end
    n_checks++; if (stale != 0) $display("[TB] FAIL burst_stale_flits: got %0d want 0", stale); else n_pass++;
    n_checks++; if (credit_cnt !== 4'd8) $display("[TB] FAIL burst_post_credit: got %0d want 8", credit_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_credit_stall();
    test_credit_same_cycle();
    test_rx_overflow();
    test_misroute();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
